// File: rtl/in_switch_flex.sv
// Input dispatch switch: routes whole AXI-Stream packets to one of three PE-group
// ports or broadcasts to all three, with per-port output registers and packet counters.
module in_switch_flex #(
  parameter int DATA_W = 1536,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cfg_dest,
  input  logic              weight_switch,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata_0,
  output logic              m_axis_tvalid_0,
  input  logic              m_axis_tready_0,
  output logic              m_axis_tlast_0,
  output logic              m_weight_switch_0,
  output logic [DATA_W-1:0] m_axis_tdata_1,
  output logic              m_axis_tvalid_1,
  input  logic              m_axis_tready_1,
  output logic              m_axis_tlast_1,
  output logic              m_weight_switch_1,
  output logic [DATA_W-1:0] m_axis_tdata_2,
  output logic              m_axis_tvalid_2,
  input  logic              m_axis_tready_2,
  output logic              m_axis_tlast_2,
  output logic              m_weight_switch_2,
  output logic [CNT_W-1:0]  pkt_cnt_0,
  output logic [CNT_W-1:0]  pkt_cnt_1,
  output logic [CNT_W-1:0]  pkt_cnt_2
);

  // state  | meaning
  // IDLE   | no packet open; route by cfg_dest / weight_switch
  // STREAM | packet open; route by locked dest / ws until tlast
  typedef enum logic {ST_IDLE, ST_STREAM} state_e;

  state_e                     state_q;
  logic [1:0]                 dest_lock_q;
  logic                       ws_lock_q;

  logic [2:0]                 vld_q, vld_d;
  logic [2:0]                 last_q, last_d;
  logic [2:0]                 ws_q, ws_d;
  logic [2:0][DATA_W-1:0]     data_q, data_d;
  logic [2:0][CNT_W-1:0]      cnt_q, cnt_d;

  logic [1:0]                 eff_dest;
  logic                       eff_ws;
  logic [2:0]                 m_ready;
  logic [2:0]                 tgt;
  logic [2:0]                 free;
  logic [2:0]                 load;
  logic                       accept;

  assign m_ready = {m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};

  always_comb begin
    eff_dest = cfg_dest;
    eff_ws   = weight_switch;
    if (state_q == ST_STREAM) begin
      eff_dest = dest_lock_q;
      eff_ws   = ws_lock_q;
    end
  end

  always_comb begin
    tgt = '0;
    for (int i = 0; i < 3; i++) begin
      tgt[i] = (eff_dest == 2'd3) || (eff_dest == 2'(i));
    end
  end

  // Broadcast waits until every port can take the beat, so all three load together.
  assign free          = ~vld_q | m_ready;
  assign s_axis_tready = &(free | ~tgt);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign load          = {3{accept}} & tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dest_lock_q <= 2'd0;
      ws_lock_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && !s_axis_tlast) begin
            dest_lock_q <= cfg_dest;
            ws_lock_q   <= weight_switch;
            state_q     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (accept && s_axis_tlast) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    ws_d   = ws_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (load[i]) begin
        vld_d[i]  = 1'b1;
        data_d[i] = s_axis_tdata;
        last_d[i] = s_axis_tlast;
        ws_d[i]   = eff_ws;
        if (s_axis_tlast) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (m_ready[i]) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
      ws_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      ws_q   <= ws_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign m_axis_tdata_0    = data_q[0];
  assign m_axis_tvalid_0   = vld_q[0];
  assign m_axis_tlast_0    = last_q[0];
  assign m_weight_switch_0 = ws_q[0];
  assign m_axis_tdata_1    = data_q[1];
  assign m_axis_tvalid_1   = vld_q[1];
  assign m_axis_tlast_1    = last_q[1];
  assign m_weight_switch_1 = ws_q[1];
  assign m_axis_tdata_2    = data_q[2];
  assign m_axis_tvalid_2   = vld_q[2];
  assign m_axis_tlast_2    = last_q[2];
  assign m_weight_switch_2 = ws_q[2];
  assign pkt_cnt_0         = cnt_q[0];
  assign pkt_cnt_1         = cnt_q[1];
  assign pkt_cnt_2         = cnt_q[2];

endmodule

// File: tb/tb_in_switch_flex.sv
// Bench for in_switch_flex: a packet-level reference model feeds per-port expected
// queues; a negedge monitor pops and compares on every output handshake.
module tb_in_switch_flex;
  localparam int DATA_W = 1536;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        cfg_dest = 2'd0;
  logic              weight_switch = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic              s_tlast = 1'b0;
  logic [2:0]        mrdy = 3'b111;
  logic [DATA_W-1:0] md0, md1, md2;
  logic              mv0, mv1, mv2, ml0, ml1, ml2, mw0, mw1, mw2;
  logic [CNT_W-1:0]  pc0, pc1, pc2;

  in_switch_flex #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_dest(cfg_dest), .weight_switch(weight_switch),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata_0(md0), .m_axis_tvalid_0(mv0), .m_axis_tready_0(mrdy[0]),
    .m_axis_tlast_0(ml0), .m_weight_switch_0(mw0),
    .m_axis_tdata_1(md1), .m_axis_tvalid_1(mv1), .m_axis_tready_1(mrdy[1]),
    .m_axis_tlast_1(ml1), .m_weight_switch_1(mw1),
    .m_axis_tdata_2(md2), .m_axis_tvalid_2(mv2), .m_axis_tready_2(mrdy[2]),
    .m_axis_tlast_2(ml2), .m_weight_switch_2(mw2),
    .pkt_cnt_0(pc0), .pkt_cnt_1(pc1), .pkt_cnt_2(pc2)
  );

  logic [DATA_W-1:0] mdata [3];
  logic [CNT_W-1:0]  pcnt  [3];
  wire  [2:0]        mval  = {mv2, mv1, mv0};
  wire  [2:0]        mlast = {ml2, ml1, ml0};
  wire  [2:0]        mws   = {mw2, mw1, mw0};
  assign mdata[0] = md0;
  assign mdata[1] = md1;
  assign mdata[2] = md2;
  assign pcnt[0]  = pc0;
  assign pcnt[1]  = pc1;
  assign pcnt[2]  = pc2;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
    logic              w;
  } beat_t;

  beat_t exp_q [3][$];

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state: one holding slot per port, packet lock, counters
  bit          slot [3];
  bit          in_pkt;
  logic [1:0]  lk_dest;
  bit          lk_ws;
  int unsigned mcnt [3];
  int          rdy_pct [3];

  task automatic chk(input string nm, input int idx, input bit ok,
                     input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s[%0d] at %0t: got %0h required %0h", nm, idx, $time, act, req);
  endtask

  function automatic bit targets(input logic [1:0] d, input int i);
    return (d == 2'd3) || (int'(d) == i);
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int k = 0; k < DATA_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    in_pkt  = 0;
    lk_dest = 2'd0;
    lk_ws   = 0;
    for (int i = 0; i < 3; i++) begin
      slot[i] = 0;
      mcnt[i] = 0;
      exp_q[i].delete();
    end
  endtask

  // one clock: drive inputs, predict ready, check at negedge, update model after posedge
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit l,
                       input logic [1:0] cd, input bit w, output bit acc);
    logic [1:0] ed;
    bit ew, mr;
    beat_t b;
    s_tvalid = v; s_tdata = d; s_tlast = l; cfg_dest = cd; weight_switch = w;
    for (int i = 0; i < 3; i++) mrdy[i] = ($urandom_range(99) < rdy_pct[i]);
    ed = in_pkt ? lk_dest : cd;
    ew = in_pkt ? lk_ws : w;
    mr = 1;
    for (int i = 0; i < 3; i++) if (targets(ed, i) && slot[i] && !mrdy[i]) mr = 0;
    acc = v && mr;
    @(negedge clk);
    chk("s_axis_tready", 0, s_tready == mr, 64'(s_tready), 64'(mr));
    for (int i = 0; i < 3; i++) begin
      chk("m_axis_tvalid", i, mval[i] == slot[i], 64'(mval[i]), 64'(slot[i]));
      chk("pkt_cnt", i, pcnt[i] == CNT_W'(mcnt[i]), 64'(pcnt[i]), 64'(mcnt[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (acc && targets(ed, i)) begin
        slot[i] = 1;
        b.d = d; b.l = l; b.w = ew;
        exp_q[i].push_back(b);
        if (l) mcnt[i] = (mcnt[i] + 1) % (1 << CNT_W);
      end else if (mrdy[i]) begin
        slot[i] = 0;
      end
    end
    if (acc) begin
      if (!in_pkt && !l) begin
        in_pkt = 1; lk_dest = cd; lk_ws = w;
      end else if (in_pkt && l) begin
        in_pkt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) cycle(0, '0, 0, cfg_dest, weight_switch, a);
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input bit l, input logic [1:0] cd,
                           input bit w, input int gap_pct);
    bit a = 0;
    int tries = 0;
    while (!a && tries < 500) begin
      if ($urandom_range(99) < gap_pct) cycle(0, '0, 0, cd, w, a);
      cycle(1, d, l, cd, w, a);
      tries++;
    end
    if (!a) chk("accept_timeout", 0, a, 64'(tries), 64'(500));
  endtask

  task automatic send_pkt(input logic [1:0] cd, input int len, input bit w, input int gap_pct);
    for (int k = 0; k < len; k++) send_beat(rand_data(), k == len - 1, cd, w, gap_pct);
  endtask

  task automatic do_reset();
    s_tvalid = 0;
    rst_n = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_tvalid", i, mval[i] == 1'b0, 64'(mval[i]), 64'(0));
      chk("rst_tlast", i, mlast[i] == 1'b0, 64'(mlast[i]), 64'(0));
      chk("rst_ws", i, mws[i] == 1'b0, 64'(mws[i]), 64'(0));
      chk("rst_tdata", i, mdata[i] == '0, mdata[i][63:0], 64'(0));
      chk("rst_pkt_cnt", i, pcnt[i] == '0, 64'(pcnt[i]), 64'(0));
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // monitor: independent of stimulus, pops on each output handshake
  beat_t pv [3];
  bit    stall [3];
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) stall[i] = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stall[i]) begin
          chk("stall_valid", i, mval[i], 64'(mval[i]), 64'(1));
          chk("stall_data", i, mdata[i] == pv[i].d && mlast[i] == pv[i].l && mws[i] == pv[i].w,
              mdata[i][63:0], pv[i].d[63:0]);
        end
        if (mval[i] && mrdy[i]) begin
          chk("beat_expected", i, exp_q[i].size() != 0, 64'(0), 64'(1));
          if (exp_q[i].size() != 0) begin
            b = exp_q[i].pop_front();
            chk("tdata", i, mdata[i] == b.d, mdata[i][63:0], b.d[63:0]);
            chk("tlast", i, mlast[i] == b.l, 64'(mlast[i]), 64'(b.l));
            chk("weight_switch", i, mws[i] == b.w, 64'(mws[i]), 64'(b.w));
          end
        end
        stall[i] = mval[i] && !mrdy[i];
        pv[i].d = mdata[i]; pv[i].l = mlast[i]; pv[i].w = mws[i];
      end
    end
  end

  initial begin
    bit a;
    for (int i = 0; i < 3; i++) rdy_pct[i] = 100;
    model_clear();
    do_reset();
    idle(2);

    // dest 1, 4 beats of beat index, ws=1
    for (int k = 0; k < 4; k++) send_beat(DATA_W'(k), k == 3, 2'd1, 1'b1, 0);
    idle(2);
    chk("t1_pkt_cnt_1", 1, pcnt[1] == 16'd1, 64'(pcnt[1]), 64'd1);
    chk("t1_pkt_cnt_0", 0, pcnt[0] == 16'd0, 64'(pcnt[0]), 64'd0);

    // broadcast 2 beats, port 2 stalled for 3 cycles while holding beat 0
    begin
      logic [DATA_W-1:0] d0, d1;
      d0 = rand_data(); d1 = rand_data();
      send_beat(d0, 0, 2'd3, 1'b0, 0);
      rdy_pct[2] = 0;
      for (int k = 0; k < 3; k++) begin
        cycle(1, d1, 1, 2'd3, 1'b0, a);
        chk("t2_blocked", k, !a && !s_tready, 64'(s_tready), 64'(0));
      end
      rdy_pct[2] = 100;
      send_beat(d1, 1, 2'd3, 1'b0, 0);
      idle(2);
      for (int i = 0; i < 3; i++)
        chk("t2_pkt_cnt", i, pcnt[i] == (i == 1 ? 16'd2 : 16'd1), 64'(pcnt[i]), 64'(mcnt[i]));
    end

    // dest 0 packet with cfg_dest/ws changed after beat 0, then single beat to port 2
    send_beat(rand_data(), 0, 2'd0, 1'b1, 0);
    for (int k = 1; k < 6; k++) send_beat(rand_data(), k == 5, 2'd2, 1'b0, 10);
    send_beat(rand_data(), 1, 2'd2, 1'b0, 0);
    idle(2);
    chk("t3_pkt_cnt_2", 2, pcnt[2] == 16'd2, 64'(pcnt[2]), 64'd2);

    // 100-beat stream to port 0 with 50% random ready and input gaps
    rdy_pct[0] = 50;
    send_pkt(2'd0, 100, $urandom_range(1), 20);
    rdy_pct[0] = 100;
    idle(3);

    // reset after beat 2 of a 5-beat packet to port 1
    for (int k = 0; k < 3; k++) send_beat(rand_data(), 0, 2'd1, 1'b1, 0);
    do_reset();
    send_pkt(2'd0, 3, 1'b0, 0);
    idle(2);
    chk("t5_pkt_cnt_0", 0, pcnt[0] == 16'd1, 64'(pcnt[0]), 64'd1);
    chk("t5_pkt_cnt_1", 1, pcnt[1] == 16'd0, 64'(pcnt[1]), 64'd0);

    // random mixed traffic
    for (int p = 0; p < 150; p++) begin
      for (int i = 0; i < 3; i++) rdy_pct[i] = $urandom_range(100, 40);
      send_pkt(2'($urandom_range(3)), $urandom_range(4, 1), $urandom_range(1), 15);
    end
    for (int i = 0; i < 3; i++) rdy_pct[i] = 100;
    idle(4);

    // counter wrap on port 0
    do_reset();
    for (int k = 0; k < 65535; k++) cycle(1, DATA_W'(k), 1, 2'd0, 1'b0, a);
    idle(2);
    chk("wrap_pre", 0, pcnt[0] == 16'hFFFF, 64'(pcnt[0]), 64'hFFFF);
    send_beat(DATA_W'(32'h5a5a), 1, 2'd0, 1'b0, 0);
    idle(2);
    chk("wrap_post", 0, pcnt[0] == 16'h0000, 64'(pcnt[0]), 64'h0);

    idle(3);
    for (int i = 0; i < 3; i++)
      chk("beats_outstanding", i, exp_q[i].size() == 0, 64'(exp_q[i].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
